// File: rtl/seq_pattern_gen_if.sv
// Control/status bundle between a pattern-transmitter requester and seq_pattern_gen.
// Pure wiring, no latency.
// No backpressure: start is a request level, busy/done report progress.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [CNT_W-1:0] repeat_n;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    // Requester side: issues commands, watches the serial line.
    modport master (
        output start, abort, pattern, pat_len, repeat_n,
        input  ser_out, ser_valid, busy, done
    );

    // Transmitter side.
    modport slave (
        input  start, abort, pattern, pat_len, repeat_n,
        output ser_out, ser_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends the low L pattern bits MSB-first, repeat_n+1 passes, then pulses done.
// Latency: start sampled at edge k drives the first bit from edge k; one bit per clock, no gaps between passes.
// No backpressure; abort/rst stop at the next edge. SEQ_PATTERN_GEN_PARITY_EN appends an even-parity bit per pass.
module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    seq_pattern_gen_if.slave    pg
);

`ifdef SEQ_PATTERN_GEN_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_FIN} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FIN} state_t;
`endif

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;     // effective length L
    logic [LEN_W-1:0] idx_q, idx_d;     // index of the bit currently on ser_out
    logic [CNT_W-1:0] rep_q, rep_d;     // passes still to go after the current one
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] leff_in;
    logic             pass_end;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    logic             par_q, par_d;
`endif

    // Variable bit select via shift keeps the index width independent of PAT_W.
    function automatic logic get_bit(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic [PAT_W-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

`ifdef SEQ_PATTERN_GEN_PARITY_EN
    function automatic logic calc_par(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
        logic r;
        r = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(l)) r = r ^ p[i];
        end
        return r;
    endfunction
`endif

    // Clamp the requested length: 0 or anything wider than the pattern means full width.
    always_comb begin
        leff_in = pg.pat_len;
        if (pg.pat_len == '0 || pg.pat_len > PAT_W_L) leff_in = PAT_W_L;
    end

    // Next-state and registered-output decode; outputs default to the idle values.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_end    = 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // abort wins over start while idle
                if (pg.start && !pg.abort) begin
                    pat_d       = pg.pattern;
                    len_d       = leff_in;
                    rep_d       = pg.repeat_n;
                    idx_d       = leff_in - LEN_ONE;
                    ser_out_d   = get_bit(pg.pattern, leff_in - LEN_ONE);
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_SHIFT;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                    par_d       = calc_par(pg.pattern, leff_in);
`endif
                end
            end
            ST_SHIFT: begin
                if (pg.abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q != '0) begin
                    idx_d       = idx_q - LEN_ONE;
                    ser_out_d   = get_bit(pat_q, idx_q - LEN_ONE);
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                    ser_out_d   = par_q;
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_PAR;
`else
                    pass_end    = 1'b1;
`endif
                end
            end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            ST_PAR: begin
                if (pg.abort) state_d = ST_IDLE;
                else          pass_end = 1'b1;
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Last bit of a pass is on the line: restart seamlessly or finish.
        if (pass_end) begin
            if (rep_q != '0) begin
                rep_d       = rep_q - CNT_ONE;
                idx_d       = len_q - LEN_ONE;
                ser_out_d   = get_bit(pat_q, len_q - LEN_ONE);
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
                state_d     = ST_SHIFT;
            end else begin
                done_d      = 1'b1;
                state_d     = ST_FIN;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rep_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign pg.ser_out   = ser_out_q;
    assign pg.ser_valid = ser_valid_q;
    assign pg.busy      = busy_q;
    assign pg.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: expected serial streams go into a queue, a monitor checks the line.
// Latency of the first bit and of done is measured by the stimulus side.
// Aware of SEQ_PATTERN_GEN_PARITY_EN so the same vectors serve both builds.
module tb_seq_pattern_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    byte  exp_q[$];

    seq_pattern_gen_if #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) pg ();

    seq_pattern_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .pg  (pg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one character per expected valid cycle, 'D' for the done cycle.
    task automatic push_str(input string s, input bit with_done);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (with_done) exp_q.push_back("D");
    endtask

    // Monitor: pops one expected item whenever the line carries a bit or done.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_tracks_valid", {31'd0, pg.busy}, {31'd0, pg.ser_valid});
            if (!pg.ser_valid) chk("ser_out_zero_when_invalid", {31'd0, pg.ser_out}, 32'd0);
            if (pg.ser_valid || pg.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: valid=%0b done=%0b with nothing expected at %0t",
                             pg.ser_valid, pg.done, $time);
                end else begin
                    byte e;
                    e = exp_q.pop_front();
                    if (e == "D") begin
                        chk("done_cycle", {29'd0, pg.done, pg.ser_valid, pg.busy}, 32'b100);
                    end else begin
                        chk("serial_bit", {29'd0, pg.ser_valid, pg.done, pg.ser_out},
                            {29'd0, 1'b1, 1'b0, (e == "1")});
                    end
                end
            end
        end
    end

    task automatic start_tx(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        pg.pattern  = p;
        pg.pat_len  = l;
        pg.repeat_n = r;
        pg.start    = 1'b1;
        @(posedge clk);
        #1;
        chk("first_bit_latency", {30'd0, pg.ser_valid, pg.busy}, 32'b11);
        pg.start = 1'b0;
    endtask

    // Counts cycles (negedges) until done, bounded.
    task automatic wait_done(input string name, input int exp);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (pg.done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done timeout after %0d cycles, required at %0d", name, n, exp);
        end else begin
            chk(name, n, exp);
        end
        @(posedge clk);
        #1;
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string s;
        pg.start    = 1'b0;
        pg.abort    = 1'b0;
        pg.pattern  = '0;
        pg.pat_len  = '0;
        pg.repeat_n = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {28'd0, pg.ser_out, pg.ser_valid, pg.busy, pg.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // 1: basic pass, pattern 101
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        push_str("1010", 1'b1);
        start_tx(8'b0000_0101, 4'd3, 4'd0);
        wait_done("t1_done_cycle", 5);
`else
        push_str("101", 1'b1);
        start_tx(8'b0000_0101, 4'd3, 4'd0);
        wait_done("t1_done_cycle", 4);
`endif
        chk("t1_busy_low_after", {31'd0, pg.busy}, 32'd0);

        // 2: three passes
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        push_str("101010101010", 1'b1);
        start_tx(8'b0000_0101, 4'd3, 4'd2);
        wait_done("t2_done_cycle", 13);
`else
        push_str("101101101", 1'b1);
        start_tx(8'b0000_0101, 4'd3, 4'd2);
        wait_done("t2_done_cycle", 10);
`endif

        // 3: length clamp, pat_len 0 and 9 both mean 8
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        push_str("101001010", 1'b1);
        start_tx(8'hA5, 4'd0, 4'd0);
        wait_done("t3_len0_done", 10);
        push_str("101001010", 1'b1);
        start_tx(8'hA5, 4'd9, 4'd0);
        wait_done("t3_len9_done", 10);
`else
        push_str("10100101", 1'b1);
        start_tx(8'hA5, 4'd0, 4'd0);
        wait_done("t3_len0_done", 9);
        push_str("10100101", 1'b1);
        start_tx(8'hA5, 4'd9, 4'd0);
        wait_done("t3_len9_done", 9);
`endif

        // 4: abort on the 4th valid cycle, then a clean restart
        push_str("1111", 1'b0);
        start_tx(8'hFF, 4'd8, 4'd0);
        repeat (4) @(negedge clk);
        pg.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_abort_outputs", {28'd0, pg.ser_out, pg.ser_valid, pg.busy, pg.done}, 32'd0);
        pg.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_abort_drain", exp_q.size(), 0);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        push_str("001111000", 1'b1);
        start_tx(8'h3C, 4'd8, 4'd0);
        wait_done("t4_restart_done", 10);
`else
        push_str("00111100", 1'b1);
        start_tx(8'h3C, 4'd8, 4'd0);
        wait_done("t4_restart_done", 9);
`endif

        // abort and start together in IDLE: nothing starts
        @(negedge clk);
        pg.pattern = 8'hFF;
        pg.start   = 1'b1;
        pg.abort   = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_beats_start", {30'd0, pg.ser_valid, pg.busy}, 32'd0);
        pg.start = 1'b0;
        pg.abort = 1'b0;

        // 5a / 6: second start during a pass is ignored; pattern 101, two passes
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        push_str("10101010", 1'b1);
`else
        push_str("101101", 1'b1);
`endif
        start_tx(8'b0000_0101, 4'd3, 4'd1);
        @(negedge clk);
        pg.pattern = 8'hFF;
        pg.start   = 1'b1;
        @(posedge clk);
        #1;
        pg.start = 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        wait_done("t5_busy_start_done", 8);
`else
        wait_done("t5_busy_start_done", 6);
`endif
        repeat (4) @(negedge clk);
        chk("t5_no_second_tx", {31'd0, pg.busy}, 32'd0);

        // 5b: synchronous reset mid-pass
        push_str("111", 1'b0);
        start_tx(8'hFF, 4'd8, 4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_reset_outputs", {28'd0, pg.ser_out, pg.ser_valid, pg.busy, pg.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_idle_after_reset", {30'd0, pg.ser_valid, pg.busy}, 32'd0);
        end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        push_str("1010", 1'b1);
        start_tx(8'b0000_0101, 4'd3, 4'd0);
        wait_done("t5_fresh_start_done", 5);
`else
        push_str("101", 1'b1);
        start_tx(8'b0000_0101, 4'd3, 4'd0);
        wait_done("t5_fresh_start_done", 4);
`endif

        // Maximum repeat count: 16 passes of "10"
        s = "";
        for (int i = 0; i < 16; i++) begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            s = {s, "101"};
`else
            s = {s, "10"};
`endif
        end
        push_str(s, 1'b1);
        start_tx(8'b0000_0010, 4'd2, 4'd15);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        wait_done("max_repeat_done", 49);
`else
        wait_done("max_repeat_done", 33);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
